// File: rtl/sd_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_clk_pkg
// Purpose  : Shared constants and state encoding for the SD clock generator.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package sd_clk_pkg;

    localparam int C_DEFAULT_DIV_W     = 8;
    localparam int C_DEFAULT_RESET_DIV = 62;
    localparam int C_MAX_DIV_W         = 16;

    typedef logic [1:0] sd_clk_state_t;

    localparam sd_clk_state_t C_ST_STOP     = 2'd0;
    localparam sd_clk_state_t C_ST_RUN_LOW  = 2'd1;
    localparam sd_clk_state_t C_ST_RUN_HIGH = 2'd2;

    // Largest divider representable in a counter of the given width.
    function automatic int max_div(input int width);
        return (1 << width) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : sd_clock_gen
// Purpose  : Programmable SD_CLK divider (CLK / 2*(div+1)) with glitch-free
//            reload handshake, stop/resume and rise/fall strobes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sd_clock_gen
    import sd_clk_pkg::*;
#(
    parameter int DIV_W     = C_DEFAULT_DIV_W,
    parameter int RESET_DIV = C_DEFAULT_RESET_DIV
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIVIDER,
    input  logic             DIV_LOAD,
    output logic             DIV_ACK,
    input  logic             CLK_EN,
    output logic             SD_CLK,
    output logic             SD_RISE,
    output logic             SD_FALL,
    output logic             STOPPED
);

    localparam logic [DIV_W-1:0] C_RESET_DIV = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] C_CNT_ONE   = DIV_W'(1);

    sd_clk_state_t    r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_pend;
    logic             r_pending;
    logic             r_sd_clk;
    logic             r_sd_rise;
    logic             r_sd_fall;
    logic             r_div_ack;
    logic             r_stopped;

    sd_clk_state_t    w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_active_nxt;
    logic [DIV_W-1:0] w_div_pend_nxt;
    logic             w_pending_nxt;
    logic             w_sd_clk_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_apply;
    logic             w_term;

    // Equality compare ends the phase before the counter could ever wrap.
    assign w_term = (r_cnt == r_div_active);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sd_clk_nxt = r_sd_clk;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_apply      = 1'b0;

        case (r_state)
            C_ST_STOP: begin
                w_cnt_nxt    = '0;
                w_sd_clk_nxt = 1'b0;
                w_apply      = r_pending;
                if (CLK_EN) begin
                    w_state_nxt = C_ST_RUN_LOW;
                end
            end

            C_ST_RUN_LOW: begin
                if (!CLK_EN) begin
                    w_state_nxt = C_ST_STOP;
                    w_cnt_nxt   = '0;
                end else if (w_term) begin
                    w_state_nxt  = C_ST_RUN_HIGH;
                    w_cnt_nxt    = '0;
                    w_sd_clk_nxt = 1'b1;
                    w_rise_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            C_ST_RUN_HIGH: begin
                // High phase always runs to completion; CLK_EN only matters at the fall.
                if (w_term) begin
                    w_state_nxt  = CLK_EN ? C_ST_RUN_LOW : C_ST_STOP;
                    w_cnt_nxt    = '0;
                    w_sd_clk_nxt = 1'b0;
                    w_fall_nxt   = 1'b1;
                    w_apply      = r_pending;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt  = C_ST_STOP;
                w_cnt_nxt    = '0;
                w_sd_clk_nxt = 1'b0;
            end
        endcase
    end

    // A capture in the same cycle as an application keeps the request pending.
    always_comb begin
        w_div_active_nxt = w_apply ? r_div_pend : r_div_active;
        w_div_pend_nxt   = DIV_LOAD ? DIVIDER : r_div_pend;
        if (DIV_LOAD) begin
            w_pending_nxt = 1'b1;
        end else if (w_apply) begin
            w_pending_nxt = 1'b0;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= C_ST_STOP;
            r_cnt        <= '0;
            r_div_active <= C_RESET_DIV;
            r_div_pend   <= '0;
            r_pending    <= 1'b0;
            r_sd_clk     <= 1'b0;
            r_sd_rise    <= 1'b0;
            r_sd_fall    <= 1'b0;
            r_div_ack    <= 1'b0;
            r_stopped    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div_active <= w_div_active_nxt;
            r_div_pend   <= w_div_pend_nxt;
            r_pending    <= w_pending_nxt;
            r_sd_clk     <= w_sd_clk_nxt;
            r_sd_rise    <= w_rise_nxt;
            r_sd_fall    <= w_fall_nxt;
            r_div_ack    <= w_apply;
            r_stopped    <= (w_state_nxt == C_ST_STOP);
        end
    end

    assign SD_CLK  = r_sd_clk;
    assign SD_RISE = r_sd_rise;
    assign SD_FALL = r_sd_fall;
    assign DIV_ACK = r_div_ack;
    assign STOPPED = r_stopped;

endmodule
`default_nettype wire

// File: tb/tb_sd_clock_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sd_clock_gen
// Purpose  : Self-checking bench for sd_clock_gen against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_clock_gen;

    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 62;

    logic             CLK = 1'b0;
    logic             RST;
    logic [DIV_W-1:0] DIVIDER;
    logic             DIV_LOAD;
    logic             DIV_ACK;
    logic             CLK_EN;
    logic             SD_CLK;
    logic             SD_RISE;
    logic             SD_FALL;
    logic             STOPPED;

    int vectors     = 0;
    int miscompares = 0;
    int tcyc        = 0;
    bit chk_en      = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) tcyc++;

    sd_clock_gen #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIVIDER  (DIVIDER),
        .DIV_LOAD (DIV_LOAD),
        .DIV_ACK  (DIV_ACK),
        .CLK_EN   (CLK_EN),
        .SD_CLK   (SD_CLK),
        .SD_RISE  (SD_RISE),
        .SD_FALL  (SD_FALL),
        .STOPPED  (STOPPED)
    );

    // Timeline model: each phase is scheduled to end at an absolute edge number.
    int unsigned m_edge, m_end, m_div, m_pval;
    int          m_mode;            // 0 stopped, 1 low phase, 2 high phase
    bit          m_pend, m_apply, m_enter_low;
    bit          e_clk, e_rise, e_fall, e_ack, e_stopped;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_edge = 0; m_end = 0; m_div = RESET_DIV; m_pval = 0;
            m_mode = 0; m_pend = 0;
            e_clk = 0; e_rise = 0; e_fall = 0; e_ack = 0; e_stopped = 1;
        end else begin
            m_edge++;
            e_rise = 0; e_fall = 0; m_apply = 0; m_enter_low = 0;
            if (m_mode == 0) begin
                m_apply = m_pend;
                m_enter_low = CLK_EN;
            end else if (m_mode == 1) begin
                if (!CLK_EN) begin
                    m_mode = 0;
                end else if (m_edge == m_end) begin
                    e_rise = 1;
                    m_mode = 2;
                    m_end  = m_edge + m_div + 1;
                end
            end else if (m_edge == m_end) begin
                e_fall  = 1;
                m_apply = m_pend;
                if (CLK_EN) m_enter_low = 1;
                else        m_mode = 0;
            end
            if (m_apply) m_div = m_pval;
            if (m_enter_low) begin
                m_mode = 1;
                m_end  = m_edge + m_div + 1;
            end
            e_ack = m_apply;
            if (DIV_LOAD) begin
                m_pend = 1;
                m_pval = DIVIDER;
            end else if (m_apply) begin
                m_pend = 0;
            end
            e_clk     = (m_mode == 2);
            e_stopped = (m_mode == 0);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            vectors++;
            if ({SD_CLK, SD_RISE, SD_FALL, DIV_ACK, STOPPED} !==
                {e_clk, e_rise, e_fall, e_ack, e_stopped}) begin
                miscompares++;
                $display("FAIL model cyc=%0d clk/rise/fall/ack/stopped got=%b%b%b%b%b want=%b%b%b%b%b",
                         tcyc, SD_CLK, SD_RISE, SD_FALL, DIV_ACK, STOPPED,
                         e_clk, e_rise, e_fall, e_ack, e_stopped);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0:       return SD_RISE;
            1:       return SD_FALL;
            default: return DIV_ACK;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK);
            if (sig(sel)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout sel=%0d got=none want=event within %0d cycles", sel, maxc);
        end
    endtask

    task automatic load_div(input int value);
        DIVIDER  = DIV_W'(value);
        DIV_LOAD = 1'b1;
        @(negedge CLK);
        DIV_LOAD = 1'b0;
    endtask

    int t0, r0, f0, acks;

    initial begin
        RST = 1'b1; CLK_EN = 1'b0; DIV_LOAD = 1'b0; DIVIDER = '0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_sd_clk", int'(SD_CLK), 0);
        check("reset_stopped", int'(STOPPED), 1);
        check("reset_strobes", int'({SD_RISE, SD_FALL, DIV_ACK}), 0);

        // Start-up with the identification divider
        RST = 1'b0; CLK_EN = 1'b1; t0 = tcyc;
        @(negedge CLK);
        check("stopped_after_1", int'(STOPPED), 0);
        wait_sig(0, 200);
        check("first_rise", tcyc - t0, 64);
        r0 = tcyc;
        wait_sig(1, 200);
        check("first_high_len", tcyc - r0, 63);
        f0 = tcyc;
        wait_sig(0, 200);
        check("first_low_len", tcyc - f0, 63);
        r0 = tcyc;

        // Reload to 0 during the high phase: phase completes, then CLK/2
        load_div(0);
        wait_sig(1, 200);
        check("high_kept_63", tcyc - r0, 63);
        check("ack_at_fall", int'(DIV_ACK), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("div0_toggle", int'(SD_CLK), (i % 2 == 0) ? 1 : 0);
        end

        // Two loads before one fall produce a single ack
        load_div(20);
        wait_sig(2, 10);
        wait_sig(0, 100);
        r0 = tcyc;
        load_div(3);
        load_div(5);
        wait_sig(2, 100);
        check("old_div_high", tcyc - r0, 21);
        f0 = tcyc;
        wait_sig(0, 50);
        check("new_low_len", tcyc - f0, 6);
        r0 = tcyc;
        wait_sig(1, 50);
        check("new_high_len", tcyc - r0, 6);
        acks = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DIV_ACK) acks++;
        end
        check("single_ack", acks, 0);

        // Stop requested 10 cycles into a high phase
        load_div(62);
        wait_sig(2, 20);
        wait_sig(0, 200);
        r0 = tcyc;
        repeat (10) @(negedge CLK);
        CLK_EN = 1'b0; t0 = tcyc;
        wait_sig(1, 100);
        check("high_remaining", tcyc - t0, 53);
        check("stopped_at_fall", int'(STOPPED), 1);
        acks = 0;
        repeat (150) begin
            @(negedge CLK);
            if (SD_RISE || SD_CLK) acks++;
        end
        check("no_rise_stopped", acks, 0);

        // Reload while stopped, then resume
        t0 = tcyc;
        load_div(9);
        wait_sig(2, 10);
        check("stop_ack_latency", tcyc - t0, 2);
        check("stop_ack_clk_low", int'(SD_CLK), 0);
        CLK_EN = 1'b1; t0 = tcyc;
        wait_sig(0, 50);
        check("resume_rise", tcyc - t0, 11);
        wait_sig(1, 50);
        repeat (3) @(negedge CLK);
        CLK_EN = 1'b0;
        repeat (5) @(negedge CLK);
        check("stop_from_low", int'(STOPPED), 1);
        CLK_EN = 1'b1;

        // Maximum divider
        load_div(255);
        wait_sig(2, 40);
        wait_sig(0, 600);
        r0 = tcyc;
        wait_sig(1, 600);
        check("max_high_len", tcyc - r0, 256);

        // Asynchronous reset during a high phase
        load_div(5);
        wait_sig(2, 600);
        wait_sig(0, 20);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_clk", int'(SD_CLK), 0);
        check("async_rst_stopped", int'(STOPPED), 1);
        @(negedge CLK);
        RST = 1'b0; t0 = tcyc;
        wait_sig(0, 200);
        check("rst_div_restored", tcyc - t0, 64);

        // Random traffic checked against the model
        repeat (4000) begin
            @(negedge CLK);
            DIV_LOAD = ($urandom_range(0, 19) == 0);
            DIVIDER  = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 255))
                                                   : DIV_W'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) CLK_EN = ~CLK_EN;
        end
        DIV_LOAD = 1'b0;
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
